// File: rtl/exe_stage_unit_if.sv
// rtl/exe_stage_unit_if.sv - decoder-to-EXE bundle and EXE/MEM register outputs
interface exe_stage_unit_if #(
  parameter int WIDTH = 32
);
  // Hazard controls
  logic             freeze;
  logic             flush;
  // Decoded instruction bundle
  logic             valid_in;
  logic [3:0]       Exe_CMD;
  logic             Mem_R_En;
  logic             Mem_W_En;
  logic             WB_En;
  logic             B;
  logic             S;
  logic [WIDTH-1:0] Val_Rn;
  logic [WIDTH-1:0] Val2;
  logic [WIDTH-1:0] Val_Rm;
  logic [3:0]       Dest;
  logic [WIDTH-1:0] PC;
  logic [23:0]      Imm24;
  // Results
  logic [3:0]       status_out;
  logic             branch_taken;
  logic [WIDTH-1:0] branch_addr;
  logic [WIDTH-1:0] alu_result_q;
  logic [WIDTH-1:0] st_val_q;
  logic [3:0]       dest_q;
  logic             mem_r_en_q;
  logic             mem_w_en_q;
  logic             wb_en_q;

  // Upstream side: drives the instruction bundle, observes the results
  modport master (
    output freeze, flush, valid_in, Exe_CMD, Mem_R_En, Mem_W_En, WB_En, B, S,
           Val_Rn, Val2, Val_Rm, Dest, PC, Imm24,
    input  status_out, branch_taken, branch_addr, alu_result_q, st_val_q,
           dest_q, mem_r_en_q, mem_w_en_q, wb_en_q
  );

  // Execute stage side
  modport slave (
    input  freeze, flush, valid_in, Exe_CMD, Mem_R_En, Mem_W_En, WB_En, B, S,
           Val_Rn, Val2, Val_Rm, Dest, PC, Imm24,
    output status_out, branch_taken, branch_addr, alu_result_q, st_val_q,
           dest_q, mem_r_en_q, mem_w_en_q, wb_en_q
  );
endinterface

// File: rtl/exe_stage_unit.sv
// rtl/exe_stage_unit.sv - ARM execute stage: ALU, NZCV register, branch target, EXE/MEM register
module exe_stage_unit #(
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  exe_stage_unit_if.slave bus
);

  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;

  logic [3:0]       status_q, status_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d;
  logic [WIDTH-1:0] st_val_q, st_val_d;
  logic [3:0]       dest_q, dest_d;
  logic             mem_r_en_q, mem_r_en_d;
  logic             mem_w_en_q, mem_w_en_d;
  logic             wb_en_q, wb_en_d;

  logic             live;
  logic             c_in;
  logic [WIDTH:0]   sum_w;
  logic [WIDTH-1:0] alu_res;
  logic             c_f;
  logic             v_f;
  logic             flag_en;
  logic             rn_msb;
  logic             v2_msb;

  assign live   = bus.valid_in & ~bus.flush;
  assign c_in   = status_q[1];
  assign rn_msb = bus.Val_Rn[WIDTH-1];
  assign v2_msb = bus.Val2[WIDTH-1];

  // ALU: subtraction is Rn + ~Val2 + carry-in, so bit WIDTH is directly the NOT-borrow carry
  always_comb begin
    sum_w   = '0;
    alu_res = '0;
    c_f     = status_q[1];
    v_f     = status_q[0];
    flag_en = 1'b1;
    case (bus.Exe_CMD)
      CMD_MOV: alu_res = bus.Val2;
      CMD_MVN: alu_res = ~bus.Val2;
      CMD_AND: alu_res = bus.Val_Rn & bus.Val2;
      CMD_ORR: alu_res = bus.Val_Rn | bus.Val2;
      CMD_EOR: alu_res = bus.Val_Rn ^ bus.Val2;
      CMD_ADD, CMD_ADC: begin
        sum_w = {1'b0, bus.Val_Rn} + {1'b0, bus.Val2}
              + {{WIDTH{1'b0}}, (bus.Exe_CMD == CMD_ADC) & c_in};
        alu_res = sum_w[WIDTH-1:0];
        c_f     = sum_w[WIDTH];
        v_f     = (rn_msb == v2_msb) & (sum_w[WIDTH-1] != rn_msb);
      end
      CMD_SUB, CMD_SBC: begin
        sum_w = {1'b0, bus.Val_Rn} + {1'b0, ~bus.Val2}
              + {{WIDTH{1'b0}}, (bus.Exe_CMD == CMD_SUB) | c_in};
        alu_res = sum_w[WIDTH-1:0];
        c_f     = sum_w[WIDTH];
        v_f     = (rn_msb != v2_msb) & (sum_w[WIDTH-1] != rn_msb);
      end
      default: flag_en = 1'b0;
    endcase
  end

  // NZCV next state: only live, unfrozen, non-branch instructions with S and a defined opcode
  always_comb begin
    status_d = status_q;
    if (live && bus.S && !bus.B && !bus.freeze && flag_en) begin
      status_d = {alu_res[WIDTH-1], (alu_res == '0), c_f, v_f};
    end
  end

  // EXE/MEM register next state: flush beats freeze, invalid slots become zero bubbles
  always_comb begin
    alu_result_d = alu_result_q;
    st_val_d     = st_val_q;
    dest_d       = dest_q;
    mem_r_en_d   = mem_r_en_q;
    mem_w_en_d   = mem_w_en_q;
    wb_en_d      = wb_en_q;
    if (bus.flush) begin
      mem_r_en_d = 1'b0;
      mem_w_en_d = 1'b0;
      wb_en_d    = 1'b0;
    end else if (!bus.freeze) begin
      alu_result_d = bus.valid_in ? alu_res : '0;
      st_val_d     = bus.valid_in ? bus.Val_Rm : '0;
      dest_d       = bus.valid_in ? bus.Dest : 4'b0000;
      mem_r_en_d   = bus.valid_in & bus.Mem_R_En & ~bus.B;
      mem_w_en_d   = bus.valid_in & bus.Mem_W_En & ~bus.B;
      wb_en_d      = bus.valid_in & bus.WB_En;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q     <= 4'b0000;
      alu_result_q <= '0;
      st_val_q     <= '0;
      dest_q       <= 4'b0000;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      wb_en_q      <= 1'b0;
    end else begin
      status_q     <= status_d;
      alu_result_q <= alu_result_d;
      st_val_q     <= st_val_d;
      dest_q       <= dest_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_w_en_q   <= mem_w_en_d;
      wb_en_q      <= wb_en_d;
    end
  end

  assign bus.status_out   = status_q;
  assign bus.alu_result_q = alu_result_q;
  assign bus.st_val_q     = st_val_q;
  assign bus.dest_q       = dest_q;
  assign bus.mem_r_en_q   = mem_r_en_q;
  assign bus.mem_w_en_q   = mem_w_en_q;
  assign bus.wb_en_q      = wb_en_q;
  assign bus.branch_taken = live & bus.B;
  assign bus.branch_addr  = bus.PC + {{(WIDTH-26){bus.Imm24[23]}}, bus.Imm24, 2'b00};

endmodule

// File: tb/tb_exe_stage_unit.sv
// tb/tb_exe_stage_unit.sv - randomized self-checking bench for exe_stage_unit
module tb_exe_stage_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  // Reference state
  logic [3:0]  m_status;
  logic [31:0] m_alu, m_st;
  logic [3:0]  m_dest;
  logic        m_rd, m_wr, m_wb;
  bit          m_data_known;

  always #5 clk = ~clk;

  exe_stage_unit_if #(.WIDTH(W)) bus ();
  exe_stage_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Architectural ALU: flags from plain integer arithmetic and range checks
  task automatic model_alu(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                           input logic [3:0] st, output logic [31:0] res,
                           output logic [3:0] nzcv, output bit defined);
    longint ua, ub, sa, sb, us, ss, cin;
    logic cf, vf;
    ua = rn; ub = v2; sa = $signed(rn); sb = $signed(v2);
    cf = st[1]; vf = st[0]; defined = 1; res = 0;
    cin = st[1] ? 1 : 0;
    case (cmd)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd6: res = rn & v2;
      4'd7: res = rn | v2;
      4'd8: res = rn ^ v2;
      4'd2, 4'd3: begin
        us = ua + ub + ((cmd == 4'd3) ? cin : 0);
        ss = sa + sb + ((cmd == 4'd3) ? cin : 0);
        res = us[31:0];
        cf = (us >= 64'h1_0000_0000);
        vf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        longint brw;
        brw = (cmd == 4'd5) ? (1 - cin) : 0;
        us = ua - ub - brw;
        ss = sa - sb - brw;
        res = us[31:0];
        cf = (ua >= ub + brw);
        vf = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      default: defined = 0;
    endcase
    nzcv = {res[31], res == 32'd0, cf, vf};
  endtask

  task automatic model_reset();
    m_status = 0; m_alu = 0; m_st = 0; m_dest = 0;
    m_rd = 0; m_wr = 0; m_wb = 0; m_data_known = 1;
  endtask

  task automatic check_regs(input string pfx);
    chk({pfx, "_status"}, bus.status_out, m_status);
    chk({pfx, "_rd"}, bus.mem_r_en_q, m_rd);
    chk({pfx, "_wr"}, bus.mem_w_en_q, m_wr);
    chk({pfx, "_wb"}, bus.wb_en_q, m_wb);
    if (m_data_known) begin
      chk({pfx, "_alu"}, bus.alu_result_q, m_alu);
      chk({pfx, "_st"}, bus.st_val_q, m_st);
      chk({pfx, "_dest"}, bus.dest_q, m_dest);
    end
  endtask

  // One clock: check combinational branch outputs, clock, advance model, check registers
  task automatic cycle(input string pfx);
    logic [31:0] res, exp_addr;
    logic [3:0]  nzcv;
    bit          def, live;
    longint      off, pcv;
    #1;
    live = bus.valid_in && !bus.flush;
    off = $signed(bus.Imm24);
    pcv = bus.PC;
    pcv = pcv + off * 4;
    exp_addr = pcv[31:0];
    chk({pfx, "_btaken"}, bus.branch_taken, live && bus.B);
    chk({pfx, "_baddr"}, bus.branch_addr, exp_addr);
    model_alu(bus.Exe_CMD, bus.Val_Rn, bus.Val2, m_status, res, nzcv, def);
    @(posedge clk);
    if (live && bus.S && !bus.B && !bus.freeze && def) m_status = nzcv;
    if (bus.flush) begin
      m_rd = 0; m_wr = 0; m_wb = 0; m_data_known = 0;
    end else if (!bus.freeze) begin
      m_alu  = bus.valid_in ? res : 32'd0;
      m_st   = bus.valid_in ? bus.Val_Rm : 32'd0;
      m_dest = bus.valid_in ? bus.Dest : 4'd0;
      m_rd   = bus.valid_in && bus.Mem_R_En && !bus.B;
      m_wr   = bus.valid_in && bus.Mem_W_En && !bus.B;
      m_wb   = bus.valid_in && bus.WB_En;
      m_data_known = 1;
    end
    #1;
    check_regs(pfx);
  endtask

  task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] v2,
                        input logic s, input logic wb);
    bus.freeze = 0; bus.flush = 0; bus.valid_in = 1; bus.Exe_CMD = cmd;
    bus.Mem_R_En = 0; bus.Mem_W_En = 0; bus.WB_En = wb; bus.B = 0; bus.S = s;
    bus.Val_Rn = rn; bus.Val2 = v2; bus.Val_Rm = 32'hA5A5_0000 ^ rn;
    bus.Dest = 4'd3; bus.PC = 32'h0; bus.Imm24 = 24'h0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1;
    set_op(4'd0, 0, 0, 0, 0);
    bus.valid_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_regs("reset");
    chk("reset_btaken", bus.branch_taken, 1'b0);
    @(negedge clk);
    rst = 0;

    // ADD overflow into sign bit
    set_op(4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 1);
    cycle("add");
    chk("add_res_k", bus.alu_result_q, 32'h8000_0000);
    chk("add_nzcv_k", bus.status_out, 4'b1001);
    chk("add_wb_k", bus.wb_en_q, 1'b1);

    // CMP equal, then SBC with carry set, then CMP with borrow, then SBC
    set_op(4'b0100, 32'd5, 32'd5, 1, 0);
    cycle("cmp_eq");
    chk("cmp_eq_k", bus.status_out, 4'b0110);
    set_op(4'b0101, 32'd10, 32'd3, 0, 1);
    cycle("sbc_c1");
    chk("sbc_c1_k", bus.alu_result_q, 32'd7);
    set_op(4'b0100, 32'd3, 32'd5, 1, 0);
    cycle("cmp_lt");
    chk("cmp_lt_c_k", bus.status_out[1], 1'b0);
    set_op(4'b0101, 32'd10, 32'd3, 1, 1);
    cycle("sbc_c0");
    chk("sbc_c0_k", bus.alu_result_q, 32'd6);

    // Freeze across two edges with changing inputs
    set_op(4'b0010, 32'd20, 32'd22, 1, 1);
    cycle("pre_frz");
    set_op(4'b0110, 32'hFFFF_0000, 32'h1234_5678, 1, 0);
    bus.freeze = 1;
    cycle("frz1");
    bus.Exe_CMD = 4'b1001; bus.Dest = 4'd9; bus.Mem_W_En = 1;
    cycle("frz2");
    chk("frz_alu_k", bus.alu_result_q, 32'd42);
    bus.flush = 1;
    cycle("frz_flush");
    chk("frz_flush_wb_k", bus.wb_en_q, 1'b0);

    // Branch: PC 0x100, offset -2 words
    set_op(4'b0000, 0, 0, 0, 0);
    bus.B = 1; bus.PC = 32'h100; bus.Imm24 = 24'hFF_FFFE;
    #1;
    chk("br_taken_k", bus.branch_taken, 1'b1);
    chk("br_addr_k", bus.branch_addr, 32'hF8);
    cycle("br");
    bus.flush = 1;
    #1;
    chk("br_flush_k", bus.branch_taken, 1'b0);
    cycle("br_flush");

    // Load address computation
    set_op(4'b0010, 32'h400, 32'h8, 0, 1);
    bus.Mem_R_En = 1; bus.Dest = 4'd11;
    cycle("load");
    chk("load_addr_k", bus.alu_result_q, 32'h408);
    chk("load_rd_k", bus.mem_r_en_q, 1'b1);
    chk("load_wr_k", bus.mem_w_en_q, 1'b0);
    chk("load_dest_k", bus.dest_q, 4'd11);

    // Asynchronous reset between edges
    set_op(4'b0010, 32'hFFFF_FFFF, 32'h8000_0001, 1, 1);
    cycle("pre_rst");
    chk("pre_rst_status_k", bus.status_out, 4'b1010);
    #2;
    rst = 1;
    #1;
    model_reset();
    check_regs("async_rst");
    #2;
    rst = 0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      bus.freeze   = ($urandom_range(0, 4) == 0);
      bus.flush    = ($urandom_range(0, 7) == 0);
      bus.valid_in = ($urandom_range(0, 3) != 0);
      bus.Exe_CMD  = 4'($urandom_range(0, 15));
      bus.Mem_R_En = $urandom_range(0, 1);
      bus.Mem_W_En = $urandom_range(0, 1);
      bus.WB_En    = $urandom_range(0, 1);
      bus.B        = ($urandom_range(0, 7) == 0);
      bus.S        = $urandom_range(0, 1);
      bus.Val_Rn   = pick_operand();
      bus.Val2     = pick_operand();
      bus.Val_Rm   = $urandom;
      bus.Dest     = 4'($urandom_range(0, 15));
      bus.PC       = $urandom;
      bus.Imm24    = 24'($urandom);
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
